alu_cmd_sequencer: RTL



---
 rtl/alu_cmd_sequencer_if.sv | 29 ++
 rtl/alu_cmd_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels between an initiator and the ALU command sequencer.
// The master side issues commands and consumes responses; the slave side is the sequencer.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [3:0]       cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_tag;
    logic [1:0]       rsp_opcode;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_opcode, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_opcode, rsp_err
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives a combinational ALU from tagged commands, samples its result after a fixed
// settle time, and flags any sampled result that disagrees with the expected operation.
module alu_cmd_sequencer #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_cmd_sequencer_if.slave bus,
    output logic [1:0]         alu_opcode,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_result,
    output logic               err_seen,
    output logic [15:0]        op_count,
    output logic               busy
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       settle_cnt;
    logic [3:0]       tag_q;
    logic             accept;
    logic             sample;
    logic             rsp_done;
    logic [WIDTH-1:0] exp_result;
    logic             mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        accept        = 1'b0;
        sample        = 1'b0;
        rsp_done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    sample     = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    rsp_done   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Reference copy of the ALU; carry and borrow fall off the top naturally.
    always_comb begin
        exp_result = '0;
        case (alu_opcode)
            2'b00: exp_result = alu_a + alu_b;
            2'b01: exp_result = alu_a - alu_b;
            2'b10: exp_result = alu_a & alu_b;
            2'b11: exp_result = alu_a | alu_b;
        endcase
    end

    assign mismatch = (alu_result != exp_result);

    // ALU operands only move on acceptance so the ALU sees no glitches while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode     <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            tag_q          <= '0;
            settle_cnt     <= '0;
            bus.rsp_result <= '0;
            bus.rsp_tag    <= '0;
            bus.rsp_opcode <= '0;
            bus.rsp_err    <= 1'b0;
            err_seen       <= 1'b0;
            op_count       <= '0;
        end else begin
            if (accept) begin
                alu_opcode <= bus.cmd_opcode;
                alu_a      <= bus.cmd_a;
                alu_b      <= bus.cmd_b;
                tag_q      <= bus.cmd_tag;
                settle_cnt <= 4'(SETTLE - 1);
            end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (sample) begin
                bus.rsp_result <= alu_result;
                bus.rsp_tag    <= tag_q;
                bus.rsp_opcode <= alu_opcode;
                bus.rsp_err    <= mismatch;
                if (mismatch) begin
                    err_seen <= 1'b1;
                end
            end
            if (rsp_done && op_count != 16'hFFFF) begin
                op_count <= op_count + 16'd1;
            end
        end
    end
endmodule
